// File: rtl/wb_video_arbiter.sv
// wb_video_arbiter: two-master Wishbone arbiter, video fetcher (m0) priority with CPU (m1) starvation guard.
module wb_video_arbiter #(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [AWIDTH-1:0]   m0_adr_i,
  input  logic [DWIDTH/8-1:0] m0_sel_i,
  input  logic [DWIDTH-1:0]   m0_dat_i,
  output logic [DWIDTH-1:0]   m0_dat_o,
  output logic                m0_ack_o,
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [AWIDTH-1:0]   m1_adr_i,
  input  logic [DWIDTH/8-1:0] m1_sel_i,
  input  logic [DWIDTH-1:0]   m1_dat_i,
  output logic [DWIDTH-1:0]   m1_dat_o,
  output logic                m1_ack_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [AWIDTH-1:0]   s_adr_o,
  output logic [DWIDTH/8-1:0] s_sel_o,
  output logic [DWIDTH-1:0]   s_dat_o,
  input  logic [DWIDTH-1:0]   s_dat_i,
  input  logic                s_ack_i,
  output logic [1:0]          grant_o
);
  localparam int SW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  localparam logic [1:0] S_IDLE = 2'd0, S_GNT0 = 2'd1, S_GNT1 = 2'd2;
  logic [1:0] state, state_nxt;
  logic [SW-1:0] starve;
  logic g0, g1, arb, starved;
  assign g0 = state == S_GNT0;
  assign g1 = state == S_GNT1;
  // Re-arbitrate only when idle or when the owner has released its cycle
  assign arb = state == S_IDLE || (g0 && !m0_cyc_i) || (g1 && !m1_cyc_i);
  assign starved = STARVE_LIMIT != 0 && starve == LIMIT;
  always_comb begin
    state_nxt = !arb ? state :
                (m1_cyc_i && starved) ? S_GNT1 :
                m0_cyc_i ? S_GNT0 :
                m1_cyc_i ? S_GNT1 : S_IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= S_IDLE;
      grant_o <= 2'b00;
      starve  <= '0;
    end else begin
      state   <= state_nxt;
      grant_o <= {state_nxt == S_GNT1, state_nxt == S_GNT0};
      if (state_nxt == S_GNT1 && !g1) starve <= '0;
      else if (m1_cyc_i && !g1 && starve != LIMIT) starve <= starve + SW'(1);
    end
  end
  assign s_cyc_o  = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
  assign s_stb_o  = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
  assign s_we_o   = g0 ? m0_we_i  : g1 ? m1_we_i  : 1'b0;
  assign s_adr_o  = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
  assign s_sel_o  = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
  assign s_dat_o  = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
  assign m0_ack_o = g0 & s_ack_i;
  assign m1_ack_o = g1 & s_ack_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
endmodule

// File: tb/tb_wb_video_arbiter.sv
// tb_wb_video_arbiter: directed bench with an ack scoreboard for wb_video_arbiter (STARVE_LIMIT=4).
module tb_wb_video_arbiter;
  logic clk_i = 1'b0;
  logic rst_ni;
  logic m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, m0_dat_o, m1_dat_o;
  logic [3:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic m0_ack_o, m1_ack_o, s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [1:0] grant_o;
  logic ack_r, force_ack;
  logic [31:0] dat_r;
  int n_tests = 0, n_fail = 0;
  typedef struct packed {logic id; logic [31:0] dat;} exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  wb_video_arbiter #(.AWIDTH(32), .DWIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return (a == 32'h1000) ? 32'hA5A5A5A5 : a ^ 32'h5A5A0000;
  endfunction

  // Single-wait-state slave: acks one cycle after seeing a strobe, never twice in a row
  always @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      ack_r <= 1'b0;
      dat_r <= '0;
    end else begin
      ack_r <= s_cyc_o && s_stb_o && !ack_r;
      dat_r <= rdata(s_adr_o);
    end
  assign s_ack_i = ack_r | force_ack;
  assign s_dat_i = dat_r;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic id, input logic [31:0] dat);
    sb_q.push_back({id, dat});
  endtask

  always @(negedge clk_i)
    if (m0_ack_o || m1_ack_o) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL ack_unexpected: got m0_ack=%b m1_ack=%b expected no ack at %0t", m0_ack_o, m1_ack_o, $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("ack_owner", {30'd0, m1_ack_o, m0_ack_o}, mon_e.id ? 32'd2 : 32'd1);
        chk("ack_data", mon_e.id ? m1_dat_o : m0_dat_o, mon_e.dat);
      end
    end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic m0_set(input logic cyc, input logic stb, input logic [31:0] adr);
    m0_cyc_i = cyc; m0_stb_i = stb; m0_adr_i = adr;
  endtask

  task automatic m1_set(input logic cyc, input logic stb, input logic [31:0] adr);
    m1_cyc_i = cyc; m1_stb_i = stb; m1_adr_i = adr;
  endtask

  task automatic do_reset;
    rst_ni = 1'b0;
    force_ack = 1'b0;
    m0_set(0, 0, 0);
    m1_set(0, 0, 0);
    tick;
    tick;
    rst_ni = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b1;
    force_ack = 1'b1;
    m0_we_i = 0; m1_we_i = 0; m0_sel_i = 4'hF; m1_sel_i = 4'h3;
    m0_dat_i = 32'h11111111; m1_dat_i = 32'h22222222;
    m0_set(1, 0, 32'h1000);
    m1_set(1, 0, 32'h2000);
    // Reset forces outputs low without a clock, even with both requesting and ack high
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_async_cyc", s_cyc_o, 0);
    chk("rst_async_adr", s_adr_o, 0);
    tick;
    tick;
    chk("rst_grant", grant_o, 0);
    chk("rst_s_ctl", {s_cyc_o, s_stb_o, s_we_o}, 0);
    chk("rst_s_sel_dat", {s_sel_o, s_dat_o[27:0]}, 0);
    chk("rst_acks", {m0_ack_o, m1_ack_o}, 0);
    rst_ni = 1'b1;
    force_ack = 1'b0;
    tick;
    chk("rst_release_grant", grant_o, 2'b01);

    // Priority and back-to-back handover
    do_reset;
    m0_set(1, 1, 32'h1000);
    m1_set(1, 1, 32'h2000);
    push_exp(0, 32'hA5A5A5A5);
    push_exp(1, 32'h5A5A2000);
    tick;
    chk("prio_grant", grant_o, 2'b01);
    chk("prio_adr", s_adr_o, 32'h1000);
    chk("prio_sel", s_sel_o, 4'hF);
    chk("prio_cyc", s_cyc_o, 1);
    tick;
    tick;
    m0_set(0, 0, 0);
    tick;
    chk("handover_grant", grant_o, 2'b10);
    chk("handover_adr", s_adr_o, 32'h2000);
    chk("handover_starve", dut.starve, 0);
    tick;
    tick;
    m1_set(0, 0, 0);
    tick;
    chk("handover_idle", {grant_o, s_cyc_o}, 0);

    // m1 keeps ownership for five beats while m0 waits
    do_reset;
    m1_set(1, 1, 32'h3000);
    for (int i = 0; i < 5; i++) push_exp(1, 32'h5A5A3000);
    push_exp(0, 32'hA5A5A5A5);
    tick;
    m0_set(1, 1, 32'h1000);
    for (int i = 0; i < 9; i++) begin
      tick;
      chk("hold_grant", grant_o, 2'b10);
    end
    tick;
    m1_set(0, 0, 0);
    chk("hold_last", grant_o, 2'b10);
    tick;
    chk("hold_release_grant", grant_o, 2'b01);
    chk("hold_release_adr", s_adr_o, 32'h1000);
    tick;
    tick;
    m0_set(0, 0, 0);
    tick;

    // m0 streams single-word cycles; m1 takes the first release
    do_reset;
    m0_set(1, 1, 32'h1000);
    m1_set(1, 1, 32'h2000);
    push_exp(0, 32'hA5A5A5A5);
    push_exp(1, 32'h5A5A2000);
    tick;
    tick;
    tick;
    m0_set(0, 0, 0);
    tick;
    chk("stream_m1_grant", grant_o, 2'b10);
    chk("stream_starve_clr", dut.starve, 0);
    m0_set(1, 1, 32'h1000);
    tick;
    tick;
    m1_set(0, 0, 0);
    push_exp(0, 32'hA5A5A5A5);
    tick;
    chk("stream_m0_back", grant_o, 2'b01);
    tick;
    tick;
    m0_set(0, 0, 0);
    tick;

    // Saturated starve counter lets m1 beat m0 in a simultaneous request
    do_reset;
    m0_set(1, 0, 32'h1000);
    m1_set(1, 0, 32'h2000);
    for (int i = 0; i < 6; i++) tick;
    chk("starve_sat", dut.starve, 4);
    m0_set(0, 0, 0);
    m1_set(0, 0, 0);
    tick;
    chk("starve_idle_grant", grant_o, 0);
    chk("starve_hold", dut.starve, 4);
    m0_set(1, 0, 32'h1000);
    m1_set(1, 0, 32'h2000);
    tick;
    chk("starve_win", grant_o, 2'b10);
    chk("starve_clr", dut.starve, 0);
    m1_set(0, 0, 0);
    tick;
    chk("starve_m0_after", grant_o, 2'b01);
    m0_set(0, 0, 0);
    tick;
    m0_set(1, 0, 32'h1000);
    m1_set(1, 0, 32'h2000);
    tick;
    chk("starve_prio_again", grant_o, 2'b01);
    m0_set(0, 0, 0);
    m1_set(0, 1, 32'h2000);
    tick;
    tick;
    chk("stb_no_cyc_grant", grant_o, 0);
    chk("stb_no_cyc_stb", s_stb_o, 0);

    // Reset in the middle of an m1 transfer
    do_reset;
    m1_set(1, 1, 32'h2000);
    tick;
    chk("midrst_grant", grant_o, 2'b10);
    chk("midrst_cyc_before", s_cyc_o, 1);
    #1 rst_ni = 1'b0;
    #1;
    chk("midrst_cyc_async", s_cyc_o, 0);
    chk("midrst_grant_async", grant_o, 0);
    m1_set(0, 0, 0);
    m0_set(1, 0, 32'h1000);
    tick;
    rst_ni = 1'b1;
    tick;
    chk("midrst_m0_grant", grant_o, 2'b01);
    m0_set(0, 0, 0);
    tick;
    tick;
    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_video_arbiter.md
Name: wb_video_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter that shares the system memory bus between the video line fetcher (master 0) and the CPU data port (master 1).
- Master 0 has fixed priority so the video line FIFO never starves.
- A starvation counter guarantees the CPU a grant after a bounded wait.
- Sits between the masters and the memory-side bus decoder, on the CPU/memory clock.

Parameters:
- AWIDTH, 32, address width of all three ports.
- DWIDTH, 32, data width; select width is DWIDTH/8.
- STARVE_LIMIT, 64, number of waiting cycles after which master 1 wins the next arbitration; 0 disables fairness (pure priority).

Ports:
- clk_i  in  1  system/memory clock; all logic on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls.
- m0_adr_i  in  AWIDTH  master 0 address.
- m0_sel_i  in  DWIDTH/8  master 0 byte selects.
- m0_dat_i  in  DWIDTH  master 0 write data.
- m0_dat_o  out  DWIDTH  read data to master 0.
- m0_ack_o  out  1  acknowledge to master 0.
- m1_*  same set as m0_*  CPU master.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side controls.
- s_adr_o  out  AWIDTH  slave address.
- s_sel_o  out  DWIDTH/8  slave byte selects.
- s_dat_o  out  DWIDTH  slave write data.
- s_dat_i  in  DWIDTH  slave read data.
- s_ack_i  in  1  slave acknowledge.
- grant_o  out  2  one-hot current owner (bit0 = m0, bit1 = m1); 2'b00 when idle.

Behaviour:
- States: S_IDLE, S_GNT0, S_GNT1. State, grant_o and starve counter are registers; the bus mux is combinational from the registered state.
- Reset (rst_ni low, asynchronous): state S_IDLE, starve counter 0, grant_o 0. All s_* outputs are 0 and m*_ack_o are 0 immediately, with no clock needed. A transfer in flight is abandoned; masters are reset by the same net.
- Arbitration runs in S_IDLE, and in S_GNTx on any edge where the owner's cyc is sampled low:
  - if m1_cyc_i and STARVE_LIMIT != 0 and starve == STARVE_LIMIT, go to S_GNT1;
  - else if m0_cyc_i, go to S_GNT0;
  - else if m1_cyc_i, go to S_GNT1;
  - else go to S_IDLE.
- Handover is back-to-back: the owner drops cyc at edge N, and the new owner is driven on the slave from cycle N+1. There is no forced idle cycle.
- Ownership holds while the owner's cyc_i is high, regardless of the other master. This preserves multi-beat and read-modify-write cycles.
- Grant latency from S_IDLE: a request sampled at edge N drives s_cyc_o from cycle N+1.
- In S_GNTx:
  - s_cyc_o = mx_cyc_i; s_stb_o = mx_stb_i.
  - s_adr_o, s_we_o, s_sel_o and s_dat_o come from master x.
  - mx_ack_o = s_ack_i; the other master's ack is 0.
- In S_IDLE: s_cyc_o = s_stb_o = s_we_o = 0; s_adr_o, s_sel_o and s_dat_o are 0; both acks are 0.
- m0_dat_o and m1_dat_o are both driven from s_dat_i at all times. Only ack qualifies the data.
- Starve counter, width clog2(STARVE_LIMIT+1):
  - increments each cycle m1_cyc_i is high and state != S_GNT1;
  - saturates at STARVE_LIMIT;
  - clears to 0 on entering S_GNT1;
  - holds when m1_cyc_i is low.
- An s_ack_i arriving while in S_IDLE is ignored and not forwarded.
- A master raising stb without cyc is never granted.

Test Plan:
- Reset: hold rst_ni=0 with both masters requesting and s_ack_i=1 -> all s_* = 0, grant_o=00, acks 0; release, then on next edge grant_o=01.
- Priority: m0 and m1 both raise cyc at edge 10 -> grant_o=01 at cycle 11; s_adr_o=m0_adr_i; m1_ack_o stays 0 when the slave acks.
- Handover: m0 does single read of 0x1000 (ack data 0xA5A5A5A5) then drops cyc with m1 pending -> m0_dat_o=0xA5A5A5A5 with m0_ack_o; grant_o=10 the very next cycle; no idle gap.
- Hold: m1 owns and keeps cyc high for 5 acks while m0 requests -> grant stays 10 throughout; m0 granted the cycle after m1 drops cyc.
- Starvation: STARVE_LIMIT=4; m0 issues back-to-back single-word cycles continuously while m1 requests -> m1 granted at the first m0 release after 4 waiting cycles; counter reads 0 after the grant.
- Reset mid-transfer: assert rst_ni low while grant_o=10 and stb high -> s_cyc_o falls asynchronously in the same cycle; after release, with only m0 requesting, grant_o=01.
